// File: rtl/vga_pkg.sv
// Shared VGA constants, pixel colour type and colour helper for the LED bank renderer.
package vga_pkg;

  localparam int unsigned H_ACT_START = 144;
  localparam int unsigned H_ACT_END   = 784;
  localparam int unsigned COLOR_W     = 8;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  function automatic rgb_t color_unpack(input logic [3*COLOR_W-1:0] c);
    rgb_t p;
    p.r = c[3*COLOR_W-1:2*COLOR_W];
    p.g = c[2*COLOR_W-1:COLOR_W];
    p.b = c[COLOR_W-1:0];
    return p;
  endfunction

endpackage

// File: rtl/led_box_hit.sv
// Combinational hit test for one indicator box; border flag exists only when OUTLINE_EN is defined.
module led_box_hit #(
  parameter int unsigned XL = 0,
  parameter int unsigned YT = 0,
  parameter int unsigned W  = 1,
  parameter int unsigned H  = 1
) (
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
`ifdef OUTLINE_EN
  output logic       on_border_c,
`endif
  output logic       in_box_c
);

  logic [31:0] h;
  logic [31:0] v;

  assign h = 32'(hcount);
  assign v = 32'(vcount);

  assign in_box_c = (h >= XL) && (h < XL + W) && (v >= YT) && (v < YT + H);

`ifdef OUTLINE_EN
  // First/last column and first/last line of the box.
  assign on_border_c = in_box_c &&
                       ((h == XL) || (h == XL + W - 1) || (v == YT) || (v == YT + H - 1));
`endif

endmodule

// File: rtl/vga_led_bank_renderer.sv
// Draws N_LEDS indicator boxes with per-frame latched state, blink and a 2-stage pixel pipeline.
// Optional feature: define OUTLINE_EN to draw unlit boxes as a COLOR_OFF outline.
module vga_led_bank_renderer
  import vga_pkg::*;
#(
  parameter int unsigned N_LEDS    = 6,
  parameter int unsigned BOX_W     = 40,
  parameter int unsigned BOX_H     = 40,
  parameter int unsigned GAP       = 30,
  parameter int unsigned X0        = 260,
  parameter int unsigned Y0        = 221,
  parameter logic [23:0] COLOR_ON  = 24'h89CFF0,
`ifdef OUTLINE_EN
  parameter logic [23:0] COLOR_OFF = 24'h303030,
`endif
  parameter int unsigned BLINK_DIV = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              display_pixel,
  input  logic              frame_start,
  input  logic [N_LEDS-1:0] leds,
  input  logic [N_LEDS-1:0] blink_mask,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              pix_valid
);

  localparam int unsigned PITCH = BOX_W + GAP;
  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  if (X0 + N_LEDS * BOX_W + (N_LEDS - 1) * GAP > H_ACT_END) begin : g_chk_width
    $error("vga_led_bank_renderer: box row extends past H_ACT_END");
  end
  if (BLINK_DIV == 0) begin : g_chk_blink
    $error("vga_led_bank_renderer: BLINK_DIV must be >= 1");
  end

  logic [N_LEDS-1:0] shadow_leds;
  logic [N_LEDS-1:0] shadow_blink;
  logic [CNT_W-1:0]  frame_cnt;
  logic              blink_phase;

  logic [N_LEDS-1:0] lit_c;
  logic [N_LEDS-1:0] in_box_c;
  logic [N_LEDS-1:0] on_hit_c;
  logic              in_active_c;

  logic [N_LEDS-1:0] on_q;
  logic              act_q;
  rgb_t              rgb_d;
  rgb_t              pix_q;
  logic              valid_q;

`ifdef OUTLINE_EN
  logic [N_LEDS-1:0] on_border_c;
  logic [N_LEDS-1:0] off_border_c;
  logic [N_LEDS-1:0] border_q;
`endif

  // Frame-rate state: shadow copies of the requests plus the blink divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_leds  <= '0;
      shadow_blink <= '0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
    end else if (frame_start) begin
      shadow_leds  <= leds;
      shadow_blink <= blink_mask;
      if (frame_cnt == CNT_W'(BLINK_DIV - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  assign lit_c = shadow_leds & ~(shadow_blink & {N_LEDS{blink_phase}});

  assign in_active_c = (32'(hcount) >= H_ACT_START) && (32'(hcount) < H_ACT_END) && display_pixel;

  // Box k is the k-th from the left and shows bit N_LEDS-1-k.
  for (genvar k = 0; k < int'(N_LEDS); k++) begin : g_box
    led_box_hit #(
      .XL(X0 + 32'(k) * PITCH),
      .YT(Y0),
      .W (BOX_W),
      .H (BOX_H)
    ) u_hit (
      .hcount     (hcount),
      .vcount     (vcount),
`ifdef OUTLINE_EN
      .on_border_c(on_border_c[k]),
`endif
      .in_box_c   (in_box_c[k])
    );

    assign on_hit_c[k] = in_box_c[k] & lit_c[N_LEDS-1-k];
`ifdef OUTLINE_EN
    assign off_border_c[k] = on_border_c[k] & ~lit_c[N_LEDS-1-k];
`endif
  end

  // Stage 1: lit state is folded in here so the pixel sees the shadow of its own cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_q  <= '0;
      act_q <= 1'b0;
`ifdef OUTLINE_EN
      border_q <= '0;
`endif
    end else begin
      on_q  <= on_hit_c;
      act_q <= in_active_c;
`ifdef OUTLINE_EN
      border_q <= off_border_c;
`endif
    end
  end

  // Stage 2 colour select.
  always_comb begin
    rgb_d = '0;
    if (act_q) begin
      if (|on_q) begin
        rgb_d = color_unpack(COLOR_ON);
      end
`ifdef OUTLINE_EN
      else if (|border_q) begin
        rgb_d = color_unpack(COLOR_OFF);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pix_q   <= rgb_d;
      valid_q <= act_q;
    end
  end

  assign red       = pix_q.r;
  assign green     = pix_q.g;
  assign blue      = pix_q.b;
  assign pix_valid = valid_q;

endmodule

// File: tb/tb_vga_led_bank_renderer.sv
// Directed self-checking bench for vga_led_bank_renderer (built with BLINK_DIV=2).
module tb_vga_led_bank_renderer;

  localparam logic [23:0] ON_EXP = 24'h89CFF0;
`ifdef OUTLINE_EN
  localparam logic [23:0] OFF_EXP = 24'h303030;
`else
  localparam logic [23:0] OFF_EXP = 24'h000000;
`endif

  logic       clk;
  logic       rst_n;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       display_pixel;
  logic       frame_start;
  logic [5:0] leds;
  logic [5:0] blink_mask;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       pix_valid;
  logic [23:0] rgb;

  int checks = 0;
  int errors = 0;

  assign rgb = {red, green, blue};

  vga_led_bank_renderer #(.BLINK_DIV(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hcount       (hcount),
    .vcount       (vcount),
    .display_pixel(display_pixel),
    .frame_start  (frame_start),
    .leds         (leds),
    .blink_mask   (blink_mask),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .pix_valid    (pix_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one pixel and wait until its result is at the outputs.
  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic dp);
    @(negedge clk);
    hcount = h;
    vcount = v;
    display_pixel = dp;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame(input logic [5:0] l, input logic [5:0] m);
    @(negedge clk);
    leds = l;
    blink_mask = m;
    frame_start = 1'b1;
    hcount = '0;
    vcount = '0;
    display_pixel = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    hcount = 10'd270;
    vcount = 10'd240;
    display_pixel = 1'b1;
    frame_start = 1'b0;
    leds = 6'h3F;
    blink_mask = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h exp %h", rgb, 24'h0); end
    checks++;
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", pix_valid); end
    rst_n = 1'b1;
    pix(10'd270, 10'd240, 1'b1);
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL reset_noshadow got %h exp %h", rgb, 24'h0); end
  endtask

  task automatic test_pattern;
    int hs[10] = '{259, 260, 299, 300, 270, 270, 270, 270, 649, 650};
    int vs[10] = '{240, 240, 240, 240, 220, 221, 260, 261, 240, 240};
    int on[10] = '{0,   1,   1,   0,   0,   1,   1,   0,   1,   0};
    logic [23:0] exp;
    pulse_frame(6'b101001, 6'b000000);
    for (int k = 0; k < 6; k++) begin
      pix(10'(260 + k * 70 + 20), 10'd240, 1'b1);
      exp = (k == 0 || k == 2 || k == 5) ? ON_EXP : 24'h0;
      checks++;
      if (rgb !== exp) begin errors++; $display("FAIL pattern_box%0d got %h exp %h", k, rgb, exp); end
      checks++;
      if (pix_valid !== 1'b1) begin errors++; $display("FAIL pattern_valid%0d got %b exp 1", k, pix_valid); end
    end
    for (int i = 0; i < 10; i++) begin
      pix(10'(hs[i]), 10'(vs[i]), 1'b1);
      exp = (on[i] != 0) ? ON_EXP : 24'h0;
      checks++;
      if (rgb !== exp) begin
        errors++;
        $display("FAIL edge_h%0d_v%0d got %h exp %h", hs[i], vs[i], rgb, exp);
      end
    end
  endtask

  task automatic test_latency;
    pix(10'd200, 10'd240, 1'b1);
    @(negedge clk);
    hcount = 10'd270;
    @(posedge clk);
    #1;
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL latency_1clk got %h exp %h", rgb, 24'h0); end
    @(negedge clk);
    hcount = 10'd200;
    @(posedge clk);
    #1;
    checks++;
    if (rgb !== ON_EXP) begin errors++; $display("FAIL latency_2clk got %h exp %h", rgb, ON_EXP); end
    @(posedge clk);
    #1;
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL latency_next got %h exp %h", rgb, 24'h0); end
  endtask

  task automatic test_shadow;
    @(negedge clk);
    leds = 6'b010110;
    pix(10'd270, 10'd240, 1'b1);
    checks++;
    if (rgb !== ON_EXP) begin errors++; $display("FAIL shadow_hold_k0 got %h exp %h", rgb, ON_EXP); end
    pix(10'd340, 10'd240, 1'b1);
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL shadow_hold_k1 got %h exp %h", rgb, 24'h0); end
    // Pixel sampled on the frame_start edge still uses the old shadow.
    @(negedge clk);
    frame_start = 1'b1;
    hcount = 10'd270;
    vcount = 10'd240;
    display_pixel = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rgb !== ON_EXP) begin errors++; $display("FAIL shadow_same_cycle got %h exp %h", rgb, ON_EXP); end
    @(posedge clk);
    #1;
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL shadow_new_k0 got %h exp %h", rgb, 24'h0); end
    pix(10'd340, 10'd240, 1'b1);
    checks++;
    if (rgb !== ON_EXP) begin errors++; $display("FAIL shadow_new_k1 got %h exp %h", rgb, ON_EXP); end
  endtask

  task automatic test_blink;
    int dark[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    logic [23:0] exp;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int m = 0; m < 8; m++) begin
      pulse_frame(6'h3F, 6'b000001);
      pix(10'd620, 10'd240, 1'b1);
      exp = (dark[m] != 0) ? 24'h0 : ON_EXP;
      checks++;
      if (rgb !== exp) begin errors++; $display("FAIL blink_k5_frame%0d got %h exp %h", m, rgb, exp); end
      pix(10'd270, 10'd240, 1'b1);
      checks++;
      if (rgb !== ON_EXP) begin errors++; $display("FAIL blink_k0_frame%0d got %h exp %h", m, rgb, ON_EXP); end
    end
  endtask

  task automatic test_inactive;
    int hs[5] = '{143, 270, 144, 784, 783};
    int dp[5] = '{1,   0,   1,   1,   1};
    int vl[5] = '{0,   0,   1,   0,   1};
    for (int i = 0; i < 5; i++) begin
      pix(10'(hs[i]), 10'd240, dp[i] != 0);
      checks++;
      if (rgb !== 24'h0) begin
        errors++;
        $display("FAIL inactive_rgb_h%0d got %h exp %h", hs[i], rgb, 24'h0);
      end
      checks++;
      if (pix_valid !== (vl[i] != 0)) begin
        errors++;
        $display("FAIL inactive_valid_h%0d got %b exp %0d", hs[i], pix_valid, vl[i]);
      end
    end
  endtask

  task automatic test_midreset;
    pix(10'd270, 10'd240, 1'b1);
    checks++;
    if (rgb !== ON_EXP) begin errors++; $display("FAIL midreset_pre got %h exp %h", rgb, ON_EXP); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL midreset_async_rgb got %h exp %h", rgb, 24'h0); end
    checks++;
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL midreset_async_valid got %b exp 0", pix_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    pix(10'd270, 10'd240, 1'b1);
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL midreset_black_k0 got %h exp %h", rgb, 24'h0); end
    pix(10'd620, 10'd240, 1'b1);
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL midreset_black_k5 got %h exp %h", rgb, 24'h0); end
    pulse_frame(6'h3F, 6'b000000);
    pix(10'd270, 10'd240, 1'b1);
    checks++;
    if (rgb !== ON_EXP) begin errors++; $display("FAIL midreset_relit got %h exp %h", rgb, ON_EXP); end
  endtask

  task automatic test_unlit;
    int hs[8] = '{260, 299, 270, 270, 270, 261, 610, 649};
    int vs[8] = '{240, 240, 221, 260, 240, 222, 240, 260};
    int bd[8] = '{1,   1,   1,   1,   0,   0,   1,   1};
    logic [23:0] exp;
    pulse_frame(6'b000000, 6'b000000);
    for (int i = 0; i < 8; i++) begin
      pix(10'(hs[i]), 10'(vs[i]), 1'b1);
      exp = (bd[i] != 0) ? OFF_EXP : 24'h0;
      checks++;
      if (rgb !== exp) begin
        errors++;
        $display("FAIL unlit_h%0d_v%0d got %h exp %h", hs[i], vs[i], rgb, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_pattern;
    test_latency;
    test_shadow;
    test_blink;
    test_inactive;
    test_midreset;
    test_unlit;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
